hdlc_tx_framer: RTL
===================

// Module: hdlc_tx_framer
// PURPOSE
//  HDLC transmit framer: serializes payload bytes from the Tx buffer into a bit stream on Tx, one bit per Clk.
//  Wraps each frame in opening/closing flags (01111110) and inserts a zero after five consecutive data ones.
//  Sends the abort pattern (0 then 7 ones) on request or on buffer underrun; drives all-ones idle otherwise.
//  Mirror of the Rx deframer; Tx, Tx_ValidFrame, Tx_AbortFrame, Tx_AbortedTrans feed the HDLC assertion binding.
// PARAMETERS
//  MIN_IDLE    8   ones sent after a closing flag/abort before a new Tx_Start is accepted (>=1)
//  ABORT_ONES  7   ones following the abort 0 (>=7)
// PORTS
//  Clk              in   1  clock, all logic on rising edge
//  Rst              in   1  synchronous reset, active-high
//  Tx_Start         in   1  start a frame; sampled only in IDLE with idle counter expired
//  Tx_Data          in   8  payload byte, transmitted LSB first
//  Tx_DataValid     in   1  Tx_Data holds a valid byte
//  Tx_Last          in   1  qualifies Tx_Data as final byte of frame
//  Tx_Ready         out  1  framer samples Tx_Data/Tx_DataValid/Tx_Last this cycle
//  Tx_AbortFrame    in   1  request abort of the current frame
//  Tx               out  1  serial line (registered)
//  Tx_ValidFrame    out  1  high while opening flag, data or closing flag bits are on Tx
//  Tx_AbortedTrans  out  1  level: last frame ended by abort; cleared on next accepted Tx_Start
//  Tx_Done          out  1  one-cycle pulse: closing flag fully sent
//  Tx_Busy          out  1  not in IDLE or idle counter not expired
// BEHAVIOUR
//  Reset: Tx=1, Tx_ValidFrame=0, Tx_Ready=0, Tx_Done=0, Tx_AbortedTrans=0, Tx_Busy=0, state IDLE, idle counter expired.
//  Reset mid-frame: next cycle Tx=1, no closing flag or abort emitted, frame discarded.
//  States: IDLE -> OPEN_FLAG (8 cycles) -> DATA -> CLOSE_FLAG (8 cycles) -> IDLE; OPEN_FLAG/DATA -> ABORT (1+ABORT_ONES) -> IDLE.
//  Latency: Tx_Start accepted at edge n -> first flag bit (0) on Tx in cycle n+1; Tx_ValidFrame rises same cycle.
//  Tx_Start ignored while Tx_Busy; a Tx_Start held high starts exactly one frame per acceptance.
//  Byte handshake: Tx_Ready=1 in the cycle the last bit of the current unit (opening flag or data byte) is on Tx.
//   Ready && Valid: byte loaded; its bit0 on Tx next cycle (one cycle later if a stuff 0 is pending).
//   Ready && !Valid: underrun -> ABORT next cycle, Tx_AbortedTrans=1 (empty frame after Tx_Start is an underrun).
//   Byte loaded with Tx_Last=1: no further Tx_Ready; CLOSE_FLAG follows its last bit (or its stuff 0).
//  Zero insertion: 3-bit ones counter, cleared at DATA entry and on any data 0; after 5th consecutive data 1
//   the next slot is a stuffed 0, counter cleared, shifter stalls one cycle; Tx_Ready delayed one cycle if
//   the stuff slot falls on a byte boundary; counter carries across byte boundaries; never applied to flags/abort.
//  Abort: Tx_AbortFrame sampled in OPEN_FLAG or DATA -> next cycle Tx=0, then ABORT_ONES ones; Tx_ValidFrame
//   falls with the abort 0; Tx_AbortedTrans set with the abort 0; no Tx_Done. Ignored in IDLE and CLOSE_FLAG.
//  Abort and Tx_Ready in same cycle: abort wins, byte not consumed (no handshake).
//  Tx_Done pulses in the cycle after the final closing-flag 0 is on Tx; Tx_ValidFrame falls that cycle.
//  Back-to-back: after CLOSE_FLAG or ABORT, MIN_IDLE ones are sent before Tx_Busy drops; no shared flags.
//  Idle: Tx=1 continuously outside frames.
// TESTING
//  Single byte 0x00, Tx_Last=1 -> Tx: 01111110 00000000 01111110 then ones; Tx_Done 1 cycle; ValidFrame 24 cycles.
//  Bytes 0xFF,0xFF (last) -> data bits 1111101111101111101 (3 stuffs, 19 cycles); Tx_Ready 2nd pulse delayed 1 cycle.
//  Byte 0x7E as data -> 0111110 10 stuffed (0,1,1,1,1,1,0,1,0); no 01111110 pattern between flags.
//  Tx_AbortFrame after 3 data bits of 0xA5 -> Tx: 0 then 7 ones, Tx_AbortedTrans=1, no Tx_Done, Tx_Busy low after MIN_IDLE more ones.
//  Tx_Start with Tx_DataValid=0 -> 8 flag bits then abort pattern; Tx_AbortedTrans=1; next Tx_Start clears it.
//  Rst mid-DATA -> Tx=1 next cycle, all outputs at reset values; Tx_Start during Tx_Busy ignored (no second frame).

Source files
------------

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: HDLC transmit framer. Serialises payload bytes LSB first
// between opening/closing flags (01111110), inserts a 0 after five
// consecutive data ones, emits 0 + ABORT_ONES ones on abort or underrun,
// and idles at all-ones.
//   Clk, Rst            clock, synchronous active-high reset
//   Tx_Start            start a frame (accepted only when !Tx_Busy)
//   Tx_Data/Tx_DataValid/Tx_Last  byte source, handshaken by Tx_Ready
//   Tx_AbortFrame       abort request (OPEN_FLAG/DATA only)
//   Tx                  registered serial line
//   Tx_ValidFrame       flag/data bits on Tx
//   Tx_AbortedTrans     last frame ended by abort
//   Tx_Done             closing flag fully sent (1-cycle pulse)
//   Tx_Busy             frame in progress or post-frame idle not yet elapsed
module hdlc_tx_framer #(
  parameter int unsigned MIN_IDLE   = 8,
  parameter int unsigned ABORT_ONES = 7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done,
  output logic       Tx_Busy
);

  localparam logic [7:0]  FLAG = 8'h7E;
  localparam int unsigned CW   = ($clog2(ABORT_ONES + 1) > 3) ? $clog2(ABORT_ONES + 1) : 3;
  localparam int unsigned IW   = $clog2(MIN_IDLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_DATA,
    S_CLOSE,
    S_ABORT
  } state_t;

  state_t          r_state, w_state;
  logic            r_tx, w_tx;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [IW-1:0]   r_idle, w_idle;
  logic [7:0]      r_shift, w_shift;
  logic [2:0]      r_idx, w_idx;
  logic [2:0]      r_ones, w_ones;
  logic            r_stuff, w_stuff;
  logic            r_last, w_last;
  logic            r_done, w_done;
  logic            r_aborted, w_aborted;

  logic            w_unit_end;
  logic            w_ready_slot;
  logic [2:0]      w_ones_base;
  logic [2:0]      w_load_ones;
  logic [2:0]      w_nidx;
  logic            w_nbit;
  logic [2:0]      w_fidx;

  // r_idx names the data bit on Tx; while r_stuff is set the stuffed 0 is on
  // Tx and r_idx still names the data bit that preceded it, so the next data
  // bit is r_idx+1 in both cases.
  assign w_unit_end   = r_stuff ? (r_idx == 3'd7) : ((r_idx == 3'd7) && (r_ones != 3'd5));
  assign w_ready_slot = ((r_state == S_OPEN) && (r_cnt == CW'(7))) ||
                        ((r_state == S_DATA) && w_unit_end && !r_last);
  assign w_ones_base  = (r_state == S_DATA) ? r_ones : '0;
  assign w_load_ones  = Tx_Data[0] ? (w_ones_base + 3'd1) : '0;
  assign w_nidx       = r_idx + 3'd1;
  assign w_nbit       = r_shift[w_nidx];
  assign w_fidx       = r_cnt[2:0] + 3'd1;

  assign Tx_Ready        = w_ready_slot && !Tx_AbortFrame;
  assign Tx              = r_tx;
  assign Tx_ValidFrame   = (r_state == S_OPEN) || (r_state == S_DATA) || (r_state == S_CLOSE);
  assign Tx_AbortedTrans = r_aborted;
  assign Tx_Done         = r_done;
  assign Tx_Busy         = (r_state != S_IDLE) || (r_idle != '0);

  always_comb begin
    w_state   = r_state;
    w_tx      = 1'b1;
    w_cnt     = r_cnt;
    w_idle    = r_idle;
    w_shift   = r_shift;
    w_idx     = r_idx;
    w_ones    = r_ones;
    w_stuff   = r_stuff;
    w_last    = r_last;
    w_done    = 1'b0;
    w_aborted = r_aborted;
    unique case (r_state)
      S_IDLE: begin
        if (r_idle != '0) begin
          w_idle = r_idle - IW'(1);
        end else if (Tx_Start) begin
          w_state   = S_OPEN;
          w_cnt     = '0;
          w_tx      = FLAG[0];
          w_aborted = 1'b0;
        end
      end
      S_OPEN, S_DATA: begin
        if (Tx_AbortFrame || (w_ready_slot && !Tx_DataValid)) begin
          w_state   = S_ABORT;
          w_cnt     = '0;
          w_tx      = 1'b0;
          w_aborted = 1'b1;
        end else if (w_ready_slot) begin
          w_state = S_DATA;
          w_shift = Tx_Data;
          w_idx   = '0;
          w_tx    = Tx_Data[0];
          w_ones  = w_load_ones;
          w_stuff = 1'b0;
          w_last  = Tx_Last;
        end else if (r_state == S_OPEN) begin
          w_cnt = r_cnt + CW'(1);
          w_tx  = FLAG[w_fidx];
        end else if (!r_stuff && (r_ones == 3'd5)) begin
          w_stuff = 1'b1;
          w_ones  = '0;
          w_tx    = 1'b0;
        end else if (w_unit_end) begin
          w_state = S_CLOSE;
          w_cnt   = '0;
          w_tx    = FLAG[0];
        end else begin
          w_idx   = w_nidx;
          w_tx    = w_nbit;
          w_ones  = w_nbit ? (r_ones + 3'd1) : '0;
          w_stuff = 1'b0;
        end
      end
      S_CLOSE: begin
        if (r_cnt == CW'(7)) begin
          w_state = S_IDLE;
          w_idle  = IW'(MIN_IDLE);
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
          w_tx  = FLAG[w_fidx];
        end
      end
      S_ABORT: begin
        if (r_cnt == CW'(ABORT_ONES)) begin
          w_state = S_IDLE;
          w_idle  = IW'(MIN_IDLE);
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_idle    <= '0;
      r_shift   <= '0;
      r_idx     <= '0;
      r_ones    <= '0;
      r_stuff   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tx      <= w_tx;
      r_cnt     <= w_cnt;
      r_idle    <= w_idle;
      r_shift   <= w_shift;
      r_idx     <= w_idx;
      r_ones    <= w_ones;
      r_stuff   <= w_stuff;
      r_last    <= w_last;
      r_done    <= w_done;
      r_aborted <= w_aborted;
    end
  end

endmodule
